// File: rtl/btn_operand_conditioner.sv
// Push-button / operand front end for the four-button 4-bit ALU stage.
// Synchronises and debounces four buttons and snapshots both operand banks on every new press.
module btn_operand_conditioner #(
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  input  logic [3:0] sw_a,
  input  logic [3:0] sw_b,
  output logic       btn1,
  output logic       btn2,
  output logic       btn3,
  output logic       btn4,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       press_strobe
);

  // Bit 1 of the encoding is the debounced level, so the outputs come straight off state flops.
  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b11,
    RELEASE_WAIT = 2'b10
  } db_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [11:0] sync_meta;
  logic [11:0] sync_q;
  logic [3:0]  btn_sync;
  logic [3:0]  sw_a_sync;
  logic [3:0]  sw_b_sync;

  db_state_t        state      [4];
  db_state_t        state_next [4];
  logic [CNT_W-1:0] cnt        [4];
  logic [CNT_W-1:0] cnt_next   [4];

  logic [3:0] level;
  logic [3:0] level_next;
  logic [3:0] rise;

  // Two-flop synchronisers on all twelve asynchronous inputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {btn_raw, sw_a, sw_b};
      sync_q    <= sync_meta;
    end
  end

  assign btn_sync  = sync_q[11:8];
  assign sw_a_sync = sync_q[7:4];
  assign sw_b_sync = sync_q[3:0];

  // State register for the four debounce FSMs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= RELEASED;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_next[i];
        cnt[i]   <= cnt_next[i];
      end
    end
  end

  // Next-state logic; the counter restarts on every state entry so it never wraps.
  // NOTE: defaults assigned first so no path leaves a variable unassigned (no latches).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_next[i] = state[i];
      cnt_next[i]   = cnt[i];
      case (state[i])
        RELEASED: begin
          if (btn_sync[i]) begin
            state_next[i] = PRESS_WAIT;
            cnt_next[i]   = CNT_ONE;
          end else begin
            cnt_next[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_sync[i]) begin
            state_next[i] = RELEASED;
            cnt_next[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_next[i] = PRESSED;
            cnt_next[i]   = '0;
          end else begin
            cnt_next[i]   = cnt[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!btn_sync[i]) begin
            state_next[i] = RELEASE_WAIT;
            cnt_next[i]   = CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (btn_sync[i]) begin
            state_next[i] = PRESSED;
            cnt_next[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_next[i] = RELEASED;
            cnt_next[i]   = '0;
          end else begin
            cnt_next[i]   = cnt[i] + CNT_ONE;
          end
        end
        default: begin
          state_next[i] = RELEASED;
          cnt_next[i]   = '0;
        end
      endcase
    end
  end

  // Output decode: current and next debounced levels, and per-button rising edges.
  always_comb begin
    level      = '0;
    level_next = '0;
    for (int i = 0; i < 4; i++) begin
      level[i]      = state[i][1];
      level_next[i] = state_next[i][1];
    end
    rise = level_next & ~level;
  end

  assign btn1 = level[3];
  assign btn2 = level[2];
  assign btn3 = level[1];
  assign btn4 = level[0];

  // Operand snapshot: one capture and one strobe per edge on which any button rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A            <= '0;
      B            <= '0;
      press_strobe <= 1'b0;
    end else begin
      press_strobe <= |rise;
      if (|rise) begin
        A <= sw_a_sync;
        B <= sw_b_sync;
      end
    end
  end

endmodule

// File: tb/tb_btn_operand_conditioner.sv
// Directed bench for btn_operand_conditioner: one instance with DB_CYCLES=4, one with DB_CYCLES=8.
// Inputs change 1 ns after a rising edge; that next edge is edge k, and a level change lands at edge k+1+DB.
module tb_btn_operand_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] sw_a;
  logic [3:0] sw_b;

  logic       b1_4, b2_4, b3_4, b4_4, strobe4;
  logic [3:0] a4, bb4;
  logic       b1_8, b2_8, b3_8, b4_8, strobe8;
  logic [3:0] a8, bb8;
  logic [3:0] btns4, btns8;

  int n_cmp = 0;
  int n_bad = 0;

  assign btns4 = {b1_4, b2_4, b3_4, b4_4};
  assign btns8 = {b1_8, b2_8, b3_8, b4_8};

  always #5 clk = ~clk;

  btn_operand_conditioner #(.DB_CYCLES(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_a(sw_a), .sw_b(sw_b),
    .btn1(b1_4), .btn2(b2_4), .btn3(b3_4), .btn4(b4_4),
    .A(a4), .B(bb4), .press_strobe(strobe4)
  );

  btn_operand_conditioner #(.DB_CYCLES(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_a(sw_a), .sw_b(sw_b),
    .btn1(b1_8), .btn2(b2_8), .btn3(b3_8), .btn4(b4_8),
    .A(a8), .B(bb8), .press_strobe(strobe8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; btn_raw = 4'hF; sw_a = 4'h9; sw_b = 4'h0;
    #2 rst_n = 1'b0;
    repeat (3) begin
      tick();
      if ({btns4, a4, bb4, strobe4} !== 13'h0) begin
        $display("FAIL reset_dut4: got %h expected %h", {btns4, a4, bb4, strobe4}, 13'h0); n_bad++;
      end
      n_cmp++;
      if ({btns8, a8, bb8, strobe8} !== 13'h0) begin
        $display("FAIL reset_dut8: got %h expected %h", {btns8, a8, bb8, strobe8}, 13'h0); n_bad++;
      end
      n_cmp++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({btns4, strobe4} !== 5'h0) begin
        $display("FAIL reset_release_early: edge %0d got %h expected %h", i, {btns4, strobe4}, 5'h0); n_bad++;
      end
      n_cmp++;
    end
    tick();
    if ({btns4, strobe4, a4, bb4} !== {4'hF, 1'b1, 4'h9, 4'h0}) begin
      $display("FAIL reset_release_press: got %h expected %h", {btns4, strobe4, a4, bb4}, {4'hF, 1'b1, 4'h9, 4'h0}); n_bad++;
    end
    n_cmp++;
    tick();
    if ({btns4, strobe4} !== {4'hF, 1'b0}) begin
      $display("FAIL reset_strobe_once: got %h expected %h", {btns4, strobe4}, {4'hF, 1'b0}); n_bad++;
    end
    n_cmp++;
    btn_raw = 4'h0;
    repeat (8) tick();
    if (btns4 !== 4'h0) begin
      $display("FAIL reset_cleanup: got %h expected %h", btns4, 4'h0); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_clean_press();
    sw_a = 4'h5; sw_b = 4'h3; btn_raw = 4'h8;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({btns4, strobe4} !== 5'h0) begin
        $display("FAIL press_early: edge %0d got %h expected %h", i, {btns4, strobe4}, 5'h0); n_bad++;
      end
      n_cmp++;
    end
    tick();
    if ({btns4, strobe4, a4, bb4} !== {4'h8, 1'b1, 4'h5, 4'h3}) begin
      $display("FAIL press_rise: got %h expected %h", {btns4, strobe4, a4, bb4}, {4'h8, 1'b1, 4'h5, 4'h3}); n_bad++;
    end
    n_cmp++;
    tick();
    if ({btns4, strobe4} !== {4'h8, 1'b0}) begin
      $display("FAIL press_strobe_width: got %h expected %h", {btns4, strobe4}, {4'h8, 1'b0}); n_bad++;
    end
    n_cmp++;
    btn_raw = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({btns4, strobe4} !== {4'h8, 1'b0}) begin
        $display("FAIL release_early: edge %0d got %h expected %h", i, {btns4, strobe4}, {4'h8, 1'b0}); n_bad++;
      end
      n_cmp++;
    end
    tick();
    if ({btns4, strobe4, a4, bb4} !== {4'h0, 1'b0, 4'h5, 4'h3}) begin
      $display("FAIL release_fall: got %h expected %h", {btns4, strobe4, a4, bb4}, {4'h0, 1'b0, 4'h5, 4'h3}); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    pat = 6'b110110;
    for (int i = 5; i >= 0; i--) begin
      btn_raw = {1'b0, pat[i], 2'b00};
      tick();
      if ({btns4, strobe4} !== 5'h0) begin
        $display("FAIL bounce_press: step %0d got %h expected %h", i, {btns4, strobe4}, 5'h0); n_bad++;
      end
      n_cmp++;
    end
    btn_raw = 4'h0;
    repeat (10) begin
      tick();
      if ({btns4, strobe4} !== 5'h0) begin
        $display("FAIL bounce_press_hold: got %h expected %h", {btns4, strobe4}, 5'h0); n_bad++;
      end
      n_cmp++;
    end
    btn_raw = 4'h4;
    repeat (7) tick();
    if ({btns4, strobe4} !== {4'h4, 1'b0}) begin
      $display("FAIL bounce_setup_press: got %h expected %h", {btns4, strobe4}, {4'h4, 1'b0}); n_bad++;
    end
    n_cmp++;
    for (int i = 5; i >= 0; i--) begin
      btn_raw = {1'b0, ~pat[i], 2'b00};
      tick();
      if ({btns4, strobe4} !== {4'h4, 1'b0}) begin
        $display("FAIL bounce_release: step %0d got %h expected %h", i, {btns4, strobe4}, {4'h4, 1'b0}); n_bad++;
      end
      n_cmp++;
    end
    btn_raw = 4'h4;
    repeat (10) begin
      tick();
      if ({btns4, strobe4} !== {4'h4, 1'b0}) begin
        $display("FAIL bounce_release_hold: got %h expected %h", {btns4, strobe4}, {4'h4, 1'b0}); n_bad++;
      end
      n_cmp++;
    end
    btn_raw = 4'h0;
    repeat (8) tick();
  endtask

  task automatic test_operand_hold();
    sw_a = 4'h2; sw_b = 4'h1; btn_raw = 4'h1;
    repeat (6) tick();
    if ({btns4, strobe4, a4, bb4} !== {4'h1, 1'b1, 4'h2, 4'h1}) begin
      $display("FAIL hold_capture: got %h expected %h", {btns4, strobe4, a4, bb4}, {4'h1, 1'b1, 4'h2, 4'h1}); n_bad++;
    end
    n_cmp++;
    sw_a = 4'hF;
    repeat (8) tick();
    if ({btns4, a4, bb4} !== {4'h1, 4'h2, 4'h1}) begin
      $display("FAIL hold_frozen: got %h expected %h", {btns4, a4, bb4}, {4'h1, 4'h2, 4'h1}); n_bad++;
    end
    n_cmp++;
    btn_raw = 4'h0;
    repeat (8) tick();
    if ({btns4, a4, bb4} !== {4'h0, 4'h2, 4'h1}) begin
      $display("FAIL hold_release: got %h expected %h", {btns4, a4, bb4}, {4'h0, 4'h2, 4'h1}); n_bad++;
    end
    n_cmp++;
    btn_raw = 4'h2;
    repeat (6) tick();
    if ({btns4, strobe4, a4, bb4} !== {4'h2, 1'b1, 4'hF, 4'h1}) begin
      $display("FAIL hold_recapture: got %h expected %h", {btns4, strobe4, a4, bb4}, {4'h2, 1'b1, 4'hF, 4'h1}); n_bad++;
    end
    n_cmp++;
    btn_raw = 4'h0;
    repeat (8) tick();
  endtask

  task automatic test_combined();
    int strobes;
    strobes = 0;
    sw_a = 4'h7; sw_b = 4'h6; btn_raw = 4'hA;
    for (int i = 0; i < 5; i++) begin
      tick();
      strobes += int'(strobe4);
      if (btns4 !== 4'h0) begin
        $display("FAIL combo_early: edge %0d got %h expected %h", i, btns4, 4'h0); n_bad++;
      end
      n_cmp++;
    end
    tick();
    strobes += int'(strobe4);
    if ({btns4, strobe4, a4, bb4} !== {4'hA, 1'b1, 4'h7, 4'h6}) begin
      $display("FAIL combo_rise: got %h expected %h", {btns4, strobe4, a4, bb4}, {4'hA, 1'b1, 4'h7, 4'h6}); n_bad++;
    end
    n_cmp++;
    repeat (4) begin
      tick();
      strobes += int'(strobe4);
    end
    if (strobes !== 1) begin
      $display("FAIL combo_one_strobe: got %0d expected %0d", strobes, 1); n_bad++;
    end
    n_cmp++;
    sw_a = 4'hC; sw_b = 4'hD; btn_raw = 4'hB;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({btns4, strobe4} !== {4'hA, 1'b0}) begin
        $display("FAIL combo_second_early: edge %0d got %h expected %h", i, {btns4, strobe4}, {4'hA, 1'b0}); n_bad++;
      end
      n_cmp++;
    end
    tick();
    if ({btns4, strobe4, a4, bb4} !== {4'hB, 1'b1, 4'hC, 4'hD}) begin
      $display("FAIL combo_second_rise: got %h expected %h", {btns4, strobe4, a4, bb4}, {4'hB, 1'b1, 4'hC, 4'hD}); n_bad++;
    end
    n_cmp++;
    sw_a = 4'h0; sw_b = 4'h0; btn_raw = 4'h0;
    strobes = 0;
    repeat (10) begin
      tick();
      strobes += int'(strobe4);
    end
    if ({btns4, a4, bb4} !== {4'h0, 4'hC, 4'hD} || strobes !== 0) begin
      $display("FAIL combo_release: got %h/%0d expected %h/0", {btns4, a4, bb4}, strobes, {4'h0, 4'hC, 4'hD}); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_mid_reset();
    btn_raw = 4'h1;
    repeat (5) tick();
    if (b4_8 !== 1'b0) begin
      $display("FAIL midrst_before: got %b expected %b", b4_8, 1'b0); n_bad++;
    end
    n_cmp++;
    rst_n = 1'b0;
    #1;
    if ({btns8, strobe8, a8, bb8} !== 13'h0) begin
      $display("FAIL midrst_async_clear: got %h expected %h", {btns8, strobe8, a8, bb8}, 13'h0); n_bad++;
    end
    n_cmp++;
    repeat (2) tick();
    if (b4_8 !== 1'b0) begin
      $display("FAIL midrst_during: got %b expected %b", b4_8, 1'b0); n_bad++;
    end
    n_cmp++;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if ({b4_8, strobe8} !== 2'b00) begin
        $display("FAIL midrst_redebounce: edge %0d got %b expected %b", i, {b4_8, strobe8}, 2'b00); n_bad++;
      end
      n_cmp++;
    end
    tick();
    if ({btns8, strobe8} !== {4'h1, 1'b1}) begin
      $display("FAIL midrst_rise: got %h expected %h", {btns8, strobe8}, {4'h1, 1'b1}); n_bad++;
    end
    n_cmp++;
    btn_raw = 4'h0;
    repeat (12) tick();
  endtask

  initial begin
    rst_n = 1'b1; btn_raw = 4'h0; sw_a = 4'h0; sw_b = 4'h0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_operand_hold();
    test_combined();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
